// File: rtl/tug_playfield_if.sv
// Tug-of-war playfield bus: two press pulses in; light position, scores,
// round result and match status out.
interface tug_playfield_if #(
  parameter int unsigned N_LIGHTS = 9,
  parameter int unsigned SCORE_W  = 3
);
  logic                l;
  logic                r;
  logic [N_LIGHTS-1:0] lights;
  logic [SCORE_W-1:0]  left_score;
  logic [SCORE_W-1:0]  right_score;
  logic [1:0]          winner;
  logic                game_over;

  // Driver of the press pulses, observer of the game state.
  modport master (
    output l, r,
    input  lights, left_score, right_score, winner, game_over
  );

  // The game core itself.
  modport slave (
    input  l, r,
    output lights, left_score, right_score, winner, game_over
  );
endinterface

// File: rtl/tug_playfield.sv
// Tug-of-war game core: moves a one-hot light on press pulses, detects round
// wins, keeps saturating scores and ends the match when a score hits its max.
// Optional feature macro TUG_AUTO_RESTART_EN: when defined, the WIN pause is a
// fixed RESTART_CYCLES countdown; when undefined, any press leaves WIN.
module tug_playfield #(
  parameter int unsigned N_LIGHTS       = 9,
  parameter int unsigned SCORE_W        = 3,
  parameter int unsigned RESTART_CYCLES = 16
) (
  input logic            i_clk,
  input logic            i_rst,
  tug_playfield_if.slave io_bus
);

  localparam int unsigned         C      = (N_LIGHTS - 1) / 2;
  localparam logic [N_LIGHTS-1:0] CENTRE = N_LIGHTS'(1) << C;
  localparam logic [SCORE_W-1:0]  MAX    = '1;

  localparam logic [1:0] ST_PLAY      = 2'd0;
  localparam logic [1:0] ST_WIN       = 2'd1;
  localparam logic [1:0] ST_MATCH_END = 2'd2;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_LEFT  = 2'b10;
  localparam logic [1:0] WIN_RIGHT = 2'b01;

  // Reject geometries without a single centre light or an empty pause.
  if ((N_LIGHTS < 3) || ((N_LIGHTS % 2) == 0) || (RESTART_CYCLES < 1)) begin : g_param_check
    $error("tug_playfield: invalid parameter set");
  end

  logic [1:0]          r_state;
  logic [N_LIGHTS-1:0] r_lights;
  logic [SCORE_W-1:0]  r_left_score;
  logic [SCORE_W-1:0]  r_right_score;
  logic [1:0]          r_winner;
  logic                r_game_over;

  logic [1:0]          w_state_nxt;
  logic [N_LIGHTS-1:0] w_lights_nxt;
  logic [SCORE_W-1:0]  w_left_score_nxt;
  logic [SCORE_W-1:0]  w_right_score_nxt;
  logic [1:0]          w_winner_nxt;
  logic                w_game_over_nxt;

  logic                w_l_only;
  logic                w_r_only;
  logic [SCORE_W-1:0]  w_left_inc;
  logic [SCORE_W-1:0]  w_right_inc;

  assign w_l_only    = io_bus.l & ~io_bus.r;
  assign w_r_only    = io_bus.r & ~io_bus.l;
  // Only reached from PLAY, where a score is always below MAX, so no wrap.
  assign w_left_inc  = r_left_score + SCORE_W'(1);
  assign w_right_inc = r_right_score + SCORE_W'(1);

`ifdef TUG_AUTO_RESTART_EN
  localparam int unsigned     CNT_W    = (RESTART_CYCLES > 1) ? $clog2(RESTART_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RESTART_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
`endif

  // Next-state logic for the game FSM and all registered outputs.
  always_comb begin
    w_state_nxt       = r_state;
    w_lights_nxt      = r_lights;
    w_left_score_nxt  = r_left_score;
    w_right_score_nxt = r_right_score;
    w_winner_nxt      = r_winner;
    w_game_over_nxt   = r_game_over;
`ifdef TUG_AUTO_RESTART_EN
    w_cnt_nxt         = r_cnt;
`endif

    case (r_state)
      ST_PLAY: begin
`ifdef TUG_AUTO_RESTART_EN
        // Kept loaded while playing so the count is ready on WIN entry.
        w_cnt_nxt = CNT_LOAD;
`endif
        if (w_l_only) begin
          if (r_lights[N_LIGHTS-1]) begin
            w_lights_nxt     = '0;
            w_winner_nxt     = WIN_LEFT;
            w_left_score_nxt = w_left_inc;
            if (w_left_inc == MAX) begin
              w_state_nxt     = ST_MATCH_END;
              w_game_over_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_WIN;
            end
          end else begin
            w_lights_nxt = r_lights << 1;
          end
        end else if (w_r_only) begin
          if (r_lights[0]) begin
            w_lights_nxt      = '0;
            w_winner_nxt      = WIN_RIGHT;
            w_right_score_nxt = w_right_inc;
            if (w_right_inc == MAX) begin
              w_state_nxt     = ST_MATCH_END;
              w_game_over_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_WIN;
            end
          end else begin
            w_lights_nxt = r_lights >> 1;
          end
        end
      end

      ST_WIN: begin
`ifdef TUG_AUTO_RESTART_EN
        if (r_cnt == '0) begin
          w_state_nxt  = ST_PLAY;
          w_lights_nxt = CENTRE;
          w_winner_nxt = WIN_NONE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
`else
        // The exiting press only re-centres; it never moves the light.
        if (io_bus.l || io_bus.r) begin
          w_state_nxt  = ST_PLAY;
          w_lights_nxt = CENTRE;
          w_winner_nxt = WIN_NONE;
        end
`endif
      end

      ST_MATCH_END: begin
        // Terminal until reset.
      end

      default: begin
        w_state_nxt  = ST_PLAY;
        w_lights_nxt = CENTRE;
        w_winner_nxt = WIN_NONE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_PLAY;
      r_lights      <= CENTRE;
      r_left_score  <= '0;
      r_right_score <= '0;
      r_winner      <= WIN_NONE;
      r_game_over   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_lights      <= w_lights_nxt;
      r_left_score  <= w_left_score_nxt;
      r_right_score <= w_right_score_nxt;
      r_winner      <= w_winner_nxt;
      r_game_over   <= w_game_over_nxt;
    end
  end

`ifdef TUG_AUTO_RESTART_EN
  // WIN pause countdown.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= CNT_LOAD;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end
`endif

  assign io_bus.lights      = r_lights;
  assign io_bus.left_score  = r_left_score;
  assign io_bus.right_score = r_right_score;
  assign io_bus.winner      = r_winner;
  assign io_bus.game_over   = r_game_over;

endmodule

// File: doc/tug_playfield.md
# tug_playfield

Game core for the tug-of-war design. It consumes the one-cycle press pulses produced by the two per-player button edge-detector stages. It moves a single lit LED across the playfield and detects when a round is won. It keeps a saturating per-player score and ends the match when either score reaches its maximum.

## Interface
Parameters:
- N_LIGHTS, 9: playfield width. Must be odd and ≥ 3. Centre index C = (N_LIGHTS-1)/2.
- SCORE_W, 3: score counter width. Match limit MAX = 2^SCORE_W - 1.
- RESTART_CYCLES, 16: duration of the WIN pause. Used only with TUG_AUTO_RESTART_EN. Must be ≥ 1.

Ports:
- Clock  in  1  system clock; the divided game clock.
- Reset  in  1  synchronous, active-high.
- L  in  1  left-player press pulse, one cycle wide, from the button stage.
- R  in  1  right-player press pulse, one cycle wide, from the button stage.
- lights  out  N_LIGHTS  one-hot light position; bit N_LIGHTS-1 is the leftmost light.
- leftScore  out  SCORE_W  rounds won by the left player.
- rightScore  out  SCORE_W  rounds won by the right player.
- winner  out  2  round result: 00 none, 10 left, 01 right.
- gameOver  out  1  high once a score reaches MAX.

## Operation
The state machine has three states: PLAY, WIN and MATCH_END. All outputs are registered.

Reset, evaluated at the clock edge:
- State goes to PLAY.
- lights = 1<<C.
- Both scores = 0.
- winner = 00; gameOver = 0.
- Reset has priority over every other input in every state.

PLAY, one move per cycle:
- L & ~R: the light shifts one position toward the MSB.
- R & ~L: the light shifts one position toward the LSB.
- L & R, or neither pulse: the light holds.
- L & ~R with the light at bit N_LIGHTS-1 (left round win):
  - lights = 0; winner = 10.
  - leftScore += 1.
  - Next state is MATCH_END if the new leftScore == MAX, otherwise WIN.
- R & ~L with the light at bit 0 is the right round win, handled symmetrically: winner = 01, rightScore += 1.

WIN:
- lights = 0; winner holds its value; scores hold.
- L and R never move the light.
- Exit condition is set by the configuration (see Configuration).
- On exit: lights = 1<<C, winner = 00, state goes to PLAY.

MATCH_END:
- gameOver = 1; lights = 0; winner holds.
- All inputs except Reset are ignored.
- Scores never wrap: there is no increment path beyond MAX.

Invariant: lights is exactly one-hot in PLAY and all-zero in WIN and MATCH_END.

## Timing
- Latency: a pulse sampled at edge n shows on lights, winner and the scores after edge n, i.e. one cycle.
- The round-winning edge updates lights, winner, the score and (if applicable) gameOver in the same cycle.
- A held L or R level is treated as a pulse on every cycle it is high. The upstream button stage guarantees pulses are one cycle wide.
- WIN exit with the macro undefined:
  - A pulse on L or R at edge n, with the FSM already in WIN before edge n, gives lights = 1<<C after edge n.
  - That pulse itself does not move the light.
- A pulse coincident with the round-winning edge is consumed by the win. It does not exit WIN.
- Reset asserted mid-round, during WIN, or during MATCH_END: all outputs return to reset values after that edge.

## Configuration
Macro TUG_AUTO_RESTART_EN.
- Defined:
  - WIN runs a countdown loaded with RESTART_CYCLES-1 on entry.
  - PLAY resumes (re-centre) exactly RESTART_CYCLES cycles after the winning edge.
  - L and R are ignored throughout WIN.
- Undefined:
  - No counter is instantiated.
  - WIN exits on the first L or R pulse after entry, as described under Timing.

## Test plan
All scenarios use defaults N_LIGHTS=9, SCORE_W=3.
- Reset, no input: lights=9'b000010000, scores 0/0, winner=00, gameOver=0, held for 10 cycles.
- L pulse, then R pulse, then L&R together: lights goes to 000100000, then back to 000010000, then holds at 000010000.
- 5 consecutive L pulses:
  - After the 4th pulse, lights=100000000.
  - After the 5th pulse, lights=0, winner=10, leftScore=1.
  - Macro off: the next R pulse gives lights=000010000, winner=00.
- Macro on, right wins a round: lights=0 for exactly 16 cycles, then 000010000. R pulses during the pause have no effect.
- Right wins 7 rounds: rightScore=7, gameOver=1. Further L/R pulses leave every output unchanged. Reset then restores all reset values.
- Reset asserted in the same cycle as a round-winning L pulse: scores stay 0, lights=000010000, winner=00.
